// File: rtl/transmitter_pkg.sv
// Shared definitions for the slotted bus transmitter and receiver: FSM states,
// the reserved no-packet destination and packet field offsets ({src, data, dst}).
package transmitter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_SEND
    } tx_state_e;

    // All-ones destination marks "no packet" on the bus.
    function automatic int null_id(input int id_width);
        return (1 << id_width) - 1;
    endfunction

    localparam int DST_LSB = 0;

    function automatic int data_lsb(input int id_width);
        return id_width;
    endfunction

    function automatic int src_lsb(input int id_width, input int data_width);
        return id_width + data_width;
    endfunction

endpackage

// File: rtl/transmitter_if.sv
// Send-request handshake between a node's core (master) and its transmitter (slave).
interface transmitter_if #(
    parameter int ID_WIDTH   = 1,
    parameter int DATA_WIDTH = 1
);
    logic                  send_valid;
    logic [ID_WIDTH-1:0]   send_dst;
    logic [DATA_WIDTH-1:0] send_data;
    logic                  send_ready;

    modport master (
        output send_valid,
        output send_dst,
        output send_data,
        input  send_ready
    );

    modport slave (
        input  send_valid,
        input  send_dst,
        input  send_data,
        output send_ready
    );
endinterface

// File: rtl/transmitter_tx_fifo.sv
// Send queue for the transmitter: power-of-two circular buffer, head visible on data.
module tx_fifo #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wr_data,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] data
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // NOTE: storage is not reset; an entry is only ever read after it has been written.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wr_data;
    end

    assign full  = (count == (AW+1)'(DEPTH));
    assign empty = (count == '0);
    assign data  = mem[rd_ptr];

endmodule

// File: rtl/transmitter.sv
// Slotted shared-bus transmitter: queues send requests and emits one packet in its own slot.
// Optional macro TX_PKT_COUNT_EN adds a saturating 16-bit sent_count output.
module transmitter
    import transmitter_pkg::*;
#(
    parameter int ID_WIDTH   = 1,
    parameter int DATA_WIDTH = 1,
    parameter int NUM_NODES  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [ID_WIDTH-1:0]              id,
    transmitter_if.slave                     send,
    output logic [2*ID_WIDTH+DATA_WIDTH-1:0] tx_out,
    output logic                             tx_busy
`ifdef TX_PKT_COUNT_EN
    ,
    output logic [15:0]                      sent_count
`endif
);
    localparam logic [ID_WIDTH-1:0] NULL_ID = ID_WIDTH'(null_id(ID_WIDTH));
    localparam int ENTRY_W  = ID_WIDTH + DATA_WIDTH;
    localparam int PKT_W    = 2 * ID_WIDTH + DATA_WIDTH;
    localparam int DATA_LSB = data_lsb(ID_WIDTH);
    localparam int SRC_LSB  = src_lsb(ID_WIDTH, DATA_WIDTH);

    logic [ID_WIDTH-1:0]   slot_cnt;
    tx_state_e             state;
    tx_state_e             state_next;
    logic                  push;
    logic                  pop;
    logic                  load;
    logic                  full;
    logic                  empty;
    logic [ENTRY_W-1:0]    head;
    logic [ID_WIDTH-1:0]   head_dst;
    logic [DATA_WIDTH-1:0] head_data;
    logic                  own_slot;
    logic [PKT_W-1:0]      idle_pkt;
    logic [PKT_W-1:0]      head_pkt;

    assign send.send_ready = !full;
    assign push            = send.send_valid && !full;
    assign own_slot        = (slot_cnt == id);
    assign {head_dst, head_data} = head;

    tx_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (push),
        .pop     (pop),
        .wr_data ({send.send_dst, send.send_data}),
        .full    (full),
        .empty   (empty),
        .data    (head)
    );

    always_ff @(posedge clk) begin
        if (rst)
            slot_cnt <= '0;
        else if (slot_cnt == ID_WIDTH'(NUM_NODES - 1))
            slot_cnt <= '0;
        else
            slot_cnt <= slot_cnt + ID_WIDTH'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_next;
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_next = state;
        pop        = 1'b0;
        load       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (push) state_next = ST_WAIT;
            end
            ST_WAIT: begin
                // A dropped NULL entry can leave WAIT with nothing queued.
                if (empty) begin
                    if (!push) state_next = ST_IDLE;
                end else if (own_slot) begin
                    pop = 1'b1;
                    if (head_dst != NULL_ID) begin
                        load       = 1'b1;
                        state_next = ST_SEND;
                    end
                end
            end
            ST_SEND: begin
                state_next = (empty && !push) ? ST_IDLE : ST_WAIT;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        idle_pkt = '0;
        idle_pkt[DST_LSB +: ID_WIDTH] = NULL_ID;
        idle_pkt[SRC_LSB +: ID_WIDTH] = id;
        head_pkt = '0;
        head_pkt[DST_LSB  +: ID_WIDTH]   = head_dst;
        head_pkt[DATA_LSB +: DATA_WIDTH] = head_data;
        head_pkt[SRC_LSB  +: ID_WIDTH]   = id;
    end

    always_ff @(posedge clk) begin
        if (rst)       tx_out <= idle_pkt;
        else if (load) tx_out <= head_pkt;
        else           tx_out <= idle_pkt;
    end

    assign tx_busy = !empty || (state == ST_SEND);

`ifdef TX_PKT_COUNT_EN
    always_ff @(posedge clk) begin
        if (rst)
            sent_count <= '0;
        else if (load && (sent_count != 16'hFFFF))
            sent_count <= sent_count + 16'd1;
    end
`endif

endmodule
